// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: op codes, FSM states,
// flag write-enable bit positions and the bundle of ALU control flags.
package alu_sequencer_pkg;

    localparam int W = 8;

    typedef enum logic [3:0] {
        OP_ADC = 4'd0,
        OP_SBC = 4'd1,
        OP_AND = 4'd2,
        OP_ORA = 4'd3,
        OP_EOR = 4'd4,
        OP_LSR = 4'd5,
        OP_ROR = 4'd6,
        OP_ASL = 4'd7,
        OP_ROL = 4'd8,
        OP_CMP = 4'd9,
        OP_BIT = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit positions inside FLAG_WE and the packed {N,Z,C,V} flag vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // One-hot ALU function select (BCDS may accompany SUMS) plus carry-in.
    typedef struct packed {
        logic sums;
        logic ands;
        logic ors;
        logic eors;
        logic srs;
        logic bcds;
        logic cin;
    } alu_ctrl_t;

endpackage

// File: rtl/alu_sequencer_bcd_nines_comp.sv
// Per-digit nines complement (9 - d) of a packed BCD value.
// Only meaningful when every nibble holds a valid BCD digit.
module bcd_nines_comp #(
    parameter int W = 8
) (
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // Each nibble is complemented independently; no borrow crosses digits.
    for (genvar gi = 0; gi < W / 4; gi++) begin : g_digit
        assign q_o[gi*4 +: 4] = 4'd9 - d_i[gi*4 +: 4];
    end

endmodule

// File: rtl/alu_sequencer.sv
// Issuing side of the 6502 ALU interface: latches one op per request,
// drives registered ALU controls for one EXEC cycle, samples the ALU at
// the end of EXEC and presents result, N/Z/C/V and write enables with a
// one-cycle DONE pulse.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_i,
    input  logic [3:0]   op_i,
    input  logic [W-1:0] opa_i,
    input  logic [W-1:0] opb_i,
    input  logic         c_in_i,
    input  logic         d_in_i,
    output logic [W-1:0] alu_a_o,
    output logic [W-1:0] alu_b_o,
    output logic         sums_o,
    output logic         ands_o,
    output logic         ors_o,
    output logic         eors_o,
    output logic         srs_o,
    output logic         bcds_o,
    output logic         alu_cin_o,
    input  logic [W-1:0] alu_result_i,
    input  logic         alu_of_i,
    input  logic         alu_cout_i,
    input  logic         alu_hcout_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] result_o,
    output logic         result_we_o,
    output logic         n_o,
    output logic         z_o,
    output logic         c_o,
    output logic         v_o,
    output logic [3:0]   flag_we_o
);

    state_e         state_q;
    logic           busy_q;
    logic           done_q;
    logic [3:0]     op_q;
    logic [W-1:0]   opa_q;
    logic [W-1:0]   opb_q;
    logic           c_q;
    alu_ctrl_t      ctrl_q;
    alu_ctrl_t      ctrl_d;
    logic [W-1:0]   alu_a_q;
    logic [W-1:0]   alu_a_d;
    logic [W-1:0]   alu_b_q;
    logic [W-1:0]   alu_b_d;
    logic [W-1:0]   result_q;
    logic [W-1:0]   result_d;
    logic           result_we_q;
    logic           result_we_d;
    logic [3:0]     nzcv_q;
    logic [3:0]     nzcv_d;
    logic [3:0]     flag_we_q;
    logic [3:0]     flag_we_d;
    logic [W-1:0]   opb_nines;
    logic           n_raw;
    logic           v_raw;

    // Half carry is not needed by any op mapping.
    logic unused_hcout;
    assign unused_hcout = alu_hcout_i;

    bcd_nines_comp #(.W(W)) u_nines (
        .d_i (opb_i),
        .q_o (opb_nines)
    );

    // Decode the requested op into ALU controls; registered on accept.
    always_comb begin
        ctrl_d  = '0;
        alu_a_d = opa_i;
        alu_b_d = opb_i;
        case (op_i)
            OP_ADC: begin
                ctrl_d.sums = 1'b1;
                ctrl_d.bcds = d_in_i;
                ctrl_d.cin  = c_in_i;
            end
            OP_SBC: begin
                ctrl_d.sums = 1'b1;
                ctrl_d.bcds = d_in_i;
                ctrl_d.cin  = c_in_i;
                alu_b_d     = d_in_i ? opb_nines : ~opb_i;
            end
            OP_AND: ctrl_d.ands = 1'b1;
            OP_ORA: ctrl_d.ors  = 1'b1;
            OP_EOR: ctrl_d.eors = 1'b1;
            OP_LSR, OP_ROR: ctrl_d.srs = 1'b1;
            OP_ASL: begin
                ctrl_d.sums = 1'b1;
                alu_b_d     = opa_i;
            end
            OP_ROL: begin
                ctrl_d.sums = 1'b1;
                ctrl_d.cin  = c_in_i;
                alu_b_d     = opa_i;
            end
            OP_CMP: begin
                // Compare is always binary, even in decimal mode.
                ctrl_d.sums = 1'b1;
                ctrl_d.cin  = 1'b1;
                alu_b_d     = ~opb_i;
            end
            OP_BIT: ctrl_d.ands = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    // Turn the sampled ALU outputs into result, flags and write enables.
    always_comb begin
        result_d    = alu_result_i;
        result_we_d = 1'b1;
        flag_we_d   = 4'b0000;
        v_raw       = alu_of_i;
        case (op_q)
            OP_ADC, OP_SBC:         flag_we_d = 4'b1111;
            OP_AND, OP_ORA, OP_EOR: flag_we_d = 4'b1100;
            OP_LSR, OP_ASL, OP_ROL: flag_we_d = 4'b1110;
            OP_ROR: begin
                result_d[W-1] = c_q;
                flag_we_d     = 4'b1110;
            end
            OP_CMP: begin
                result_we_d = 1'b0;
                flag_we_d   = 4'b1110;
            end
            OP_BIT: begin
                result_we_d = 1'b0;
                flag_we_d   = 4'b1101;
            end
            default: begin
                result_d    = opa_q;
                result_we_d = 1'b0;
                flag_we_d   = 4'b0000;
            end
        endcase
        // N follows the final result (after ROR injection) unless overridden.
        n_raw = result_d[W-1];
        if (op_q == OP_LSR) begin
            n_raw = 1'b0;
        end
        if (op_q == OP_BIT) begin
            n_raw = opb_q[7];
            v_raw = opb_q[6];
        end
        nzcv_d[FLAG_N] = flag_we_d[FLAG_N] ? n_raw : 1'b0;
        nzcv_d[FLAG_Z] = flag_we_d[FLAG_Z] ? (result_d == '0) : 1'b0;
        nzcv_d[FLAG_C] = flag_we_d[FLAG_C] ? alu_cout_i : c_q;
        nzcv_d[FLAG_V] = flag_we_d[FLAG_V] ? v_raw : 1'b0;
    end

    // Sequencer FSM: accept in IDLE, drive ALU in EXEC, pulse DONE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            op_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            c_q         <= 1'b0;
            ctrl_q      <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            result_q    <= '0;
            result_we_q <= 1'b0;
            nzcv_q      <= '0;
            flag_we_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (req_i) begin
                        op_q    <= op_i;
                        opa_q   <= opa_i;
                        opb_q   <= opb_i;
                        c_q     <= c_in_i;
                        ctrl_q  <= ctrl_d;
                        alu_a_q <= alu_a_d;
                        alu_b_q <= alu_b_d;
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q    <= result_d;
                    result_we_q <= result_we_d;
                    nzcv_q      <= nzcv_d;
                    flag_we_q   <= flag_we_d;
                    ctrl_q      <= '0;
                    alu_a_q     <= '0;
                    alu_b_q     <= '0;
                    done_q      <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign sums_o      = ctrl_q.sums;
    assign ands_o      = ctrl_q.ands;
    assign ors_o       = ctrl_q.ors;
    assign eors_o      = ctrl_q.eors;
    assign srs_o       = ctrl_q.srs;
    assign bcds_o      = ctrl_q.bcds;
    assign alu_cin_o   = ctrl_q.cin;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign result_o    = result_q;
    assign result_we_o = result_we_q;
    assign n_o         = nzcv_q[FLAG_N];
    assign z_o         = nzcv_q[FLAG_Z];
    assign c_o         = nzcv_q[FLAG_C];
    assign v_o         = nzcv_q[FLAG_V];
    assign flag_we_o   = flag_we_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU answers the
// sequencer's controls, and an op-level 6502 model predicts every result.
module tb_alu_sequencer;

    logic       clk;
    logic       rst;
    logic       req;
    logic [3:0] op;
    logic [7:0] opa;
    logic [7:0] opb;
    logic       c_in;
    logic       d_in;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       sums, ands, ors, eors, srs, bcds, alu_cin;
    logic [7:0] alu_result;
    logic       alu_of, alu_cout, alu_hcout;
    logic       busy, done;
    logic [7:0] result;
    logic       result_we;
    logic       n, z, c, v;
    logic [3:0] flag_we;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] res;
        logic       rwe;
        logic [3:0] nzcv;
        logic [3:0] fwe;
    } exp_t;

    alu_sequencer #(.W(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .op_i         (op),
        .opa_i        (opa),
        .opb_i        (opb),
        .c_in_i       (c_in),
        .d_in_i       (d_in),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .sums_o       (sums),
        .ands_o       (ands),
        .ors_o        (ors),
        .eors_o       (eors),
        .srs_o        (srs),
        .bcds_o       (bcds),
        .alu_cin_o    (alu_cin),
        .alu_result_i (alu_result),
        .alu_of_i     (alu_of),
        .alu_cout_i   (alu_cout),
        .alu_hcout_i  (alu_hcout),
        .busy_o       (busy),
        .done_o       (done),
        .result_o     (result),
        .result_we_o  (result_we),
        .n_o          (n),
        .z_o          (z),
        .c_o          (c),
        .v_o          (v),
        .flag_we_o    (flag_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Digit-serial decimal adder used by the behavioural ALU.
    function automatic logic [8:0] dec_add(input logic [7:0] a, input logic [7:0] b, input logic ci);
        int lo;
        int hi;
        logic hc;
        logic co;
        lo = int'(a[3:0]) + int'(b[3:0]) + int'(ci);
        hc = 1'b0;
        if (lo > 9) begin lo = lo - 10; hc = 1'b1; end
        hi = int'(a[7:4]) + int'(b[7:4]) + int'(hc);
        co = 1'b0;
        if (hi > 9) begin hi = hi - 10; co = 1'b1; end
        return {co, 4'(hi), 4'(lo)};
    endfunction

    // Behavioural ALU: responds combinationally to whatever the DUT drives.
    logic [8:0] alu_s;
    always_comb begin
        alu_s      = '0;
        alu_result = '0;
        alu_cout   = 1'b0;
        alu_of     = 1'b0;
        alu_hcout  = 1'b0;
        if (sums) begin
            if (bcds) alu_s = dec_add(alu_a, alu_b, alu_cin);
            else      alu_s = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
            alu_result = alu_s[7:0];
            alu_cout   = alu_s[8];
            alu_of     = (alu_a[7] == alu_b[7]) && (alu_s[7] != alu_a[7]);
        end else if (ands) begin
            alu_result = alu_a & alu_b;
        end else if (ors) begin
            alu_result = alu_a | alu_b;
        end else if (eors) begin
            alu_result = alu_a ^ alu_b;
        end else if (srs) begin
            alu_result = {1'b0, alu_a[7:1]};
            alu_cout   = alu_a[0];
        end
    end

    function automatic int bcd2int(input logic [7:0] x);
        return int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int x);
        return {4'(x / 10), 4'(x % 10)};
    endfunction

    // Op-level reference: 6502 semantics with plain integer arithmetic.
    function automatic exp_t ref_model(input int o, input logic [7:0] a, input logic [7:0] b,
                                       input logic ci, input logic di);
        exp_t e;
        int s;
        int si;
        logic [7:0] r;
        logic [7:0] b9;
        logic co, vv, nn, n_fixed;
        logic [3:0] fwe;
        logic rwe;
        r = a; co = ci; vv = 1'b0; nn = 1'b0; n_fixed = 1'b0; fwe = 4'b0000; rwe = 1'b1;
        case (o)
            0: begin
                fwe = 4'b1111;
                if (di) begin
                    s  = bcd2int(a) + bcd2int(b) + int'(ci);
                    co = (s >= 100);
                    r  = int2bcd(s % 100);
                    // Decimal V: sign-overflow test applied to the decimal result.
                    vv = (a[7] == b[7]) && (r[7] != a[7]);
                end else begin
                    s  = int'(a) + int'(b) + int'(ci);
                    co = (s > 255);
                    r  = 8'(s);
                    si = int'($signed(a)) + int'($signed(b)) + int'(ci);
                    vv = (si > 127) || (si < -128);
                end
            end
            1: begin
                fwe = 4'b1111;
                if (di) begin
                    s  = bcd2int(a) - bcd2int(b) - (1 - int'(ci));
                    co = (s >= 0);
                    if (s < 0) s = s + 100;
                    r  = int2bcd(s);
                    b9 = 8'h99 - b;
                    vv = (a[7] == b9[7]) && (r[7] != a[7]);
                end else begin
                    s  = int'(a) - int'(b) - (1 - int'(ci));
                    co = (s >= 0);
                    r  = 8'(s);
                    si = int'($signed(a)) - int'($signed(b)) - (1 - int'(ci));
                    vv = (si > 127) || (si < -128);
                end
            end
            2: begin r = a & b; fwe = 4'b1100; end
            3: begin r = a | b; fwe = 4'b1100; end
            4: begin r = a ^ b; fwe = 4'b1100; end
            5: begin r = a >> 1; co = a[0]; fwe = 4'b1110; nn = 1'b0; n_fixed = 1'b1; end
            6: begin r = {ci, a[7:1]}; co = a[0]; fwe = 4'b1110; end
            7: begin r = {a[6:0], 1'b0}; co = a[7]; fwe = 4'b1110; end
            8: begin r = {a[6:0], ci}; co = a[7]; fwe = 4'b1110; end
            9: begin r = a - b; co = (a >= b); rwe = 1'b0; fwe = 4'b1110; end
            10: begin r = a & b; rwe = 1'b0; fwe = 4'b1101; nn = b[7]; n_fixed = 1'b1; vv = b[6]; end
            default: begin r = a; rwe = 1'b0; fwe = 4'b0000; end
        endcase
        if (!n_fixed) nn = r[7];
        e.res  = r;
        e.rwe  = rwe;
        e.fwe  = fwe;
        e.nzcv = {fwe[3] ? nn : 1'b0, fwe[2] ? (r == 8'h00) : 1'b0,
                  fwe[1] ? co : ci, fwe[0] ? vv : 1'b0};
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return {22'd0, alu_a, alu_b, sums, ands, ors, eors, srs, bcds, alu_cin,
                busy, done, result, result_we, n, z, c, v, flag_we};
    endfunction

    logic [7:0] last_res;
    logic [3:0] last_nzcv;
    logic [3:0] last_fwe;
    logic       last_rwe;

    // One complete request: accept, EXEC, DONE, back to IDLE.
    task automatic do_op(input int o, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic di);
        exp_t e;
        int hot;
        e = ref_model(o, a, b, ci, di);
        @(negedge clk);
        req = 1'b1; op = 4'(o); opa = a; opb = b; c_in = ci; d_in = di;
        @(posedge clk); #1;
        check("accept_busy", 64'(busy), 64'd1);
        check("accept_done", 64'(done), 64'd0);
        hot = int'(sums) + int'(ands) + int'(ors) + int'(eors) + int'(srs);
        check("exec_onehot", 64'(hot), (o <= 10) ? 64'd1 : 64'd0);
        @(negedge clk);
        req = 1'b0; opa = 8'($urandom); opb = 8'($urandom); c_in = 1'($urandom); d_in = 1'($urandom);
        @(posedge clk); #1;
        check("done_pulse", 64'(done), 64'd1);
        check("result", 64'(result), 64'(e.res));
        check("result_we", 64'(result_we), 64'(e.rwe));
        check("nzcv", 64'({n, z, c, v}), 64'(e.nzcv));
        check("flag_we", 64'(flag_we), 64'(e.fwe));
        check("ctrl_idle_in_done", 64'({alu_a, alu_b, sums, ands, ors, eors, srs, bcds, alu_cin}), 64'd0);
        last_res = result; last_nzcv = {n, z, c, v}; last_fwe = flag_we; last_rwe = result_we;
        $display("op=%0d a=%02h b=%02h c=%0d d=%0d -> res=%02h we=%0d nzcv=%04b fwe=%04b",
                 o, a, b, ci, di, result, result_we, {n, z, c, v}, flag_we);
        @(posedge clk); #1;
        check("after_done", 64'({busy, done}), 64'd0);
        check("hold", 64'({result, result_we, n, z, c, v, flag_we}),
              64'({e.res, e.rwe, e.nzcv, e.fwe}));
    endtask

    initial begin
        logic [11:0] pat;
        logic [11:0] pat_exp;
        logic        seen;
        int          o;
        logic [7:0]  a, b;
        logic        ci, di;

        rst = 1'b1; req = 1'b0; op = '0; opa = '0; opb = '0; c_in = 1'b0; d_in = 1'b0;
        #2;
        check("reset_outputs", all_outputs(), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        do_op(0, 8'h50, 8'h50, 1'b0, 1'b0);
        check("adc_bin_res", 64'(last_res), 64'h0A0);
        check("adc_bin_flags", 64'({last_nzcv, last_fwe}), 64'b1001_1111);
        do_op(0, 8'h45, 8'h38, 1'b0, 1'b1);
        check("adc_dec_res", 64'({last_res, last_nzcv[1]}), 64'({8'h83, 1'b0}));
        do_op(0, 8'h99, 8'h01, 1'b0, 1'b1);
        check("adc_dec_wrap", 64'({last_res, last_nzcv[2:1]}), 64'({8'h00, 2'b11}));
        do_op(1, 8'h50, 8'h30, 1'b1, 1'b0);
        check("sbc_bin", 64'({last_res, last_nzcv[1]}), 64'({8'h20, 1'b1}));
        do_op(1, 8'h50, 8'h30, 1'b1, 1'b1);
        do_op(9, 8'h10, 8'h20, 1'b0, 1'b1);
        check("cmp", 64'({last_nzcv[3:1], last_fwe, last_rwe}), 64'({3'b100, 4'b1110, 1'b0}));
        do_op(6, 8'h01, 8'h00, 1'b1, 1'b0);
        check("ror", 64'({last_res, last_nzcv[3], last_nzcv[1]}), 64'({8'h80, 2'b11}));
        do_op(7, 8'h80, 8'h00, 1'b0, 1'b0);
        check("asl", 64'({last_res, last_nzcv[2:1]}), 64'({8'h00, 2'b11}));
        do_op(10, 8'h0F, 8'hC0, 1'b0, 1'b0);
        check("bit", 64'({last_nzcv[3:2], last_nzcv[0]}), 64'b111);
        do_op(13, 8'h5A, 8'h33, 1'b1, 1'b0);
        check("invalid_op", 64'({last_fwe, last_rwe}), 64'd0);
        do_op(5, 8'hFF, 8'h00, 1'b0, 1'b0);
        do_op(8, 8'h81, 8'h00, 1'b1, 1'b0);

        // REQ pulses during EXEC and DONE must not start another op.
        @(negedge clk);
        req = 1'b1; op = 4'd2; opa = 8'hF0; opb = 8'h3C; c_in = 1'b0; d_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        op = 4'd3; opa = 8'h01; opb = 8'h02;
        @(posedge clk); #1;
        check("ignore_req_result", 64'({done, result}), 64'({1'b1, 8'h30}));
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk); #1;
        check("ignore_req_idle", 64'({busy, done}), 64'd0);

        // REQ held high: DONE every third cycle.
        @(negedge clk);
        req = 1'b1; op = 4'd4; opa = 8'h55; opb = 8'hAA;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            pat[i] = done;
            pat_exp[i] = ((i + 1) % 3 == 2);
        end
        @(negedge clk);
        req = 1'b0;
        check("held_req_pattern", 64'(pat), 64'(pat_exp));
        repeat (2) @(posedge clk);

        // Asynchronous reset mid-EXEC drops the op.
        @(negedge clk);
        req = 1'b1; op = 4'd0; opa = 8'h12; opb = 8'h34; c_in = 1'b1; d_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        rst = 1'b1;
        #1;
        check("async_reset", all_outputs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            seen = seen | done | busy;
        end
        check("no_done_after_reset", 64'(seen), 64'd0);
        do_op(0, 8'h12, 8'h34, 1'b1, 1'b0);

        // Randomized ops against the reference model.
        for (int k = 0; k < 40; k++) begin
            o  = int'($urandom_range(0, 15));
            ci = 1'($urandom);
            di = 1'($urandom);
            a  = 8'($urandom);
            b  = 8'($urandom);
            if (di && (o <= 1)) begin
                a = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end
            do_op(o, a, b, ci, di);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
